// File: rtl/reg_readback_pkg.sv
// rtl/reg_readback_pkg.sv - shared state encodings and defaults for the register read responder
package reg_readback_pkg;

    localparam int DEF_BUS_WIDTH = 15;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

endpackage

// File: rtl/reg_readback_if.sv
// rtl/reg_readback_if.sv - read-side bus between requester/bank and the readback responder
interface reg_readback_if #(
    parameter int bus_width = 15,
    parameter int NUM_REGS  = 4,
    parameter int ADDR_W    = 2
);
    logic                              rdb;
    logic [ADDR_W-1:0]                 addr;
    logic [NUM_REGS*(bus_width+1)-1:0] reg_data;
    logic [bus_width:0]                rdout_q;
    logic                              rd_ack;
    logic                              rd_err;
    logic [NUM_REGS-1:0]               clr_stb;
    logic                              busy;

    modport master (
        output rdb, addr, reg_data,
        input  rdout_q, rd_ack, rd_err, clr_stb, busy
    );

    modport slave (
        input  rdb, addr, reg_data,
        output rdout_q, rd_ack, rd_err, clr_stb, busy
    );
endinterface

// File: rtl/reg_readback_rdbit1.sv
// rtl/reg_readback_rdbit1.sv - one bit of the read-word holding register, loads only on cap
module rdbit1 (
    input  logic clk,
    input  logic reset,
    input  logic cap,
    input  logic din,
    output logic dout
);
    logic r_q;

    always_ff @(posedge clk) begin
        if (reset)
            r_q <= 1'b0;
        else if (cap)
            r_q <= din;
    end

    assign dout = r_q;
endmodule

// File: rtl/reg_readback.sv
// rtl/reg_readback.sv - strobe-sequenced register read responder with ack and read-to-clear pulses
module reg_readback
    import reg_readback_pkg::*;
#(
    parameter int                  bus_width = DEF_BUS_WIDTH,
    parameter int                  NUM_REGS  = 4,
    parameter int                  ADDR_W    = 2,
    parameter int                  RD_WAIT   = 1,
    parameter logic [NUM_REGS-1:0] RC_MASK   = '0
) (
    input logic           sysclk,
    input logic           reset,
    reg_readback_if.slave bus
);
    localparam int W = bus_width + 1;

    logic [1:0]          r_state;
    logic                r_rdb_q;
    logic [ADDR_W-1:0]   r_addr_q;
    logic [3:0]          r_cnt;
    logic                r_err_q;

    logic                w_start;
    logic                w_cap;
    logic                w_addr_ok;
    logic [W-1:0]        w_cap_word;
    logic [W-1:0]        w_rdout;
    logic [NUM_REGS-1:0] w_clr;

    // r_rdb_q resets low so a strobe already low at reset release is not a read
    assign w_start   = (r_state == ST_IDLE) && r_rdb_q && !bus.rdb;
    assign w_cap     = (r_state == ST_WAIT) && !bus.rdb && (r_cnt == 4'd0);
    assign w_addr_ok = int'(r_addr_q) < NUM_REGS;

    always_comb begin
        w_cap_word = '0;
        for (int k = 0; k < NUM_REGS; k++)
            if (int'(r_addr_q) == k)
                w_cap_word = bus.reg_data[k*W +: W];
    end

    always_comb begin
        w_clr = '0;
        if (r_state == ST_ACK)
            for (int k = 0; k < NUM_REGS; k++)
                if (int'(r_addr_q) == k && RC_MASK[k])
                    w_clr[k] = 1'b1;
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_rdb_q  <= 1'b0;
            r_addr_q <= '0;
            r_cnt    <= 4'd0;
            r_err_q  <= 1'b0;
        end else begin
            r_rdb_q <= bus.rdb;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state  <= ST_WAIT;
                        r_addr_q <= bus.addr;
                        r_cnt    <= 4'(RD_WAIT);
                    end
                end
                ST_WAIT: begin
                    if (bus.rdb)
                        r_state <= ST_IDLE;
                    else if (r_cnt != 4'd0)
                        r_cnt <= r_cnt - 4'd1;
                    else begin
                        r_err_q <= !w_addr_ok;
                        r_state <= ST_ACK;
                    end
                end
                ST_ACK:
                    r_state <= ST_HOLD;
                default: begin
                    if (bus.rdb)
                        r_state <= ST_IDLE;
                end
            endcase
        end
    end

    for (genvar i = 0; i < W; i++) begin : rd_bits
        rdbit1 u_bit (
            .clk   (sysclk),
            .reset (reset),
            .cap   (w_cap),
            .din   (w_cap_word[i]),
            .dout  (w_rdout[i])
        );
    end

    assign bus.rdout_q = w_rdout;
    assign bus.rd_ack  = (r_state == ST_ACK);
    assign bus.rd_err  = (r_state == ST_ACK) && r_err_q;
    assign bus.clr_stb = w_clr;
    assign bus.busy    = (r_state != ST_IDLE);
endmodule

// File: tb/tb_reg_readback.sv
// tb/tb_reg_readback.sv - directed vector bench for reg_readback
module tb_reg_readback;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_readback_if #(.bus_width(15), .NUM_REGS(3), .ADDR_W(2)) ifa ();
    reg_readback_if #(.bus_width(15), .NUM_REGS(4), .ADDR_W(2)) ifb ();

    reg_readback #(.bus_width(15), .NUM_REGS(3), .ADDR_W(2), .RD_WAIT(1), .RC_MASK(3'b100))
        dut_a (.sysclk(clk), .reset(rst), .bus(ifa.slave));
    reg_readback #(.bus_width(15), .NUM_REGS(4), .ADDR_W(2), .RD_WAIT(4), .RC_MASK(4'b0001))
        dut_b (.sysclk(clk), .reset(rst), .bus(ifb.slave));

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0]  addr;
        logic [15:0] r2;
        logic [15:0] exp_data;
        logic        exp_err;
        logic [3:0]  exp_clr;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic get_ack(input bit sel);
        return sel ? ifb.rd_ack : ifa.rd_ack;
    endfunction

    function automatic logic [3:0] get_clr(input bit sel);
        return sel ? ifb.clr_stb : {1'b0, ifa.clr_stb};
    endfunction

    function automatic logic [15:0] get_data(input bit sel);
        return sel ? ifb.rdout_q : ifa.rdout_q;
    endfunction

    task automatic set_rdb(input bit sel, input logic v);
        if (sel) ifb.rdb = v; else ifa.rdb = v;
    endtask

    // Full read: strobe low, count edges to ack, check the one-cycle pulse, release strobe
    task automatic do_read(input bit sel, input logic [1:0] addr, input int exp_lat,
                           input logic [15:0] exp_data, input logic exp_err, input logic [3:0] exp_clr);
        int lat;
        logic err;
        logic [3:0] clr;
        @(negedge clk);
        if (sel) ifb.addr = addr; else ifa.addr = addr;
        set_rdb(sel, 1'b0);
        lat = 0;
        err = 1'b0;
        clr = '0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (get_ack(sel)) begin
                err = sel ? ifb.rd_err : ifa.rd_err;
                clr = get_clr(sel);
                break;
            end
        end
        chk("latency", lat, exp_lat);
        chk("rdout_q", get_data(sel), exp_data);
        chk("rd_err", err, exp_err);
        chk("clr_stb", clr, exp_clr);
        @(negedge clk);
        chk("ack_one_cycle", get_ack(sel), 1'b0);
        chk("clr_one_cycle", get_clr(sel), 4'b0);
        set_rdb(sel, 1'b1);
        repeat (2) @(negedge clk);
        chk("rdout_held", get_data(sel), exp_data);
        chk("busy_idle", sel ? ifb.busy : ifa.busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ack_seen;
        logic busy_seen;

        vecs[0] = '{2'd2, 16'hA5C3, 16'hA5C3, 1'b0, 4'b0100};
        vecs[1] = '{2'd1, 16'hA5C3, 16'hBEEF, 1'b0, 4'b0000};
        vecs[2] = '{2'd3, 16'hA5C3, 16'h0000, 1'b1, 4'b0000};
        vecs[3] = '{2'd0, 16'hA5C3, 16'h1234, 1'b0, 4'b0000};
        vecs[4] = '{2'd2, 16'h0F0F, 16'h0F0F, 1'b0, 4'b0100};

        rst = 1'b1;
        ifa.rdb = 1'b0; ifa.addr = '0;
        ifb.rdb = 1'b0; ifb.addr = '0;
        ifa.reg_data = {16'hA5C3, 16'hBEEF, 16'h1234};
        ifb.reg_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};

        // Strobe held low through and after reset must not start a read
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_rdout", ifa.rdout_q, 16'h0);
        chk("rst_ack", ifa.rd_ack, 1'b0);
        ack_seen = 1'b0;
        busy_seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            ack_seen  |= ifa.rd_ack | ifb.rd_ack;
            busy_seen |= ifa.busy | ifb.busy;
        end
        chk("low_after_rst_ack", ack_seen, 1'b0);
        chk("low_after_rst_busy", busy_seen, 1'b0);
        chk("low_after_rst_rdout", ifa.rdout_q, 16'h0);
        ifa.rdb = 1'b1;
        ifb.rdb = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            ifa.reg_data[47:32] = vecs[i].r2;
            do_read(1'b0, vecs[i].addr, 3, vecs[i].exp_data, vecs[i].exp_err, vecs[i].exp_clr);
        end

        // Abort during wait keeps the previous word and issues no ack
        do_read(1'b1, 2'd3, 6, 16'h4444, 1'b0, 4'b0000);
        @(negedge clk);
        ifb.addr = 2'd1;
        ifb.rdb = 1'b0;
        repeat (2) @(negedge clk);
        ifb.rdb = 1'b1;
        ack_seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            ack_seen |= ifb.rd_ack;
        end
        chk("abort_no_ack", ack_seen, 1'b0);
        chk("abort_rdout", ifb.rdout_q, 16'h4444);
        chk("abort_busy", ifb.busy, 1'b0);
        do_read(1'b1, 2'd0, 6, 16'h1111, 1'b0, 4'b0001);

        // Reset while waiting
        @(negedge clk);
        ifb.addr = 2'd2;
        ifb.rdb = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstwait_rdout", ifb.rdout_q, 16'h0);
        chk("rstwait_busy", ifb.busy, 1'b0);
        rst = 1'b0;
        ack_seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            ack_seen |= ifb.rd_ack;
        end
        chk("rstwait_no_ack", ack_seen, 1'b0);
        ifb.rdb = 1'b1;
        repeat (2) @(negedge clk);

        // Reset in the ack cycle
        ifa.addr = 2'd2;
        ifa.rdb = 1'b0;
        ack_seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ifa.rd_ack) begin
                ack_seen = 1'b1;
                break;
            end
        end
        chk("rstack_reached", ack_seen, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstack_ack", ifa.rd_ack, 1'b0);
        chk("rstack_clr", {1'b0, ifa.clr_stb}, 4'b0);
        chk("rstack_err", ifa.rd_err, 1'b0);
        chk("rstack_rdout", ifa.rdout_q, 16'h0);
        chk("rstack_busy", ifa.busy, 1'b0);
        rst = 1'b0;
        ack_seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            ack_seen |= ifa.rd_ack;
        end
        chk("rstack_no_ack", ack_seen, 1'b0);
        ifa.rdb = 1'b1;
        repeat (2) @(negedge clk);
        do_read(1'b0, 2'd1, 3, 16'hBEEF, 1'b0, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
